// File: rtl/rr_psel_gen.sv
// Registered round-robin multi-grant selector: picks up to REQS of WIDTH requests
// per cycle, searching from a rotating priority pointer so no requester starves.
module rr_psel_gen #(
   parameter  int REQS  = 3,
   parameter  int WIDTH = 16,
   localparam int PW    = $clog2(WIDTH),
   localparam int CW    = $clog2(REQS + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    stall,
   input  logic [WIDTH-1:0]        req,
   output logic [WIDTH*REQS-1:0]   gnt_bus,
   output logic [WIDTH-1:0]        gnt,
   output logic [CW-1:0]           gnt_count,
   output logic [PW-1:0]           ptr
);

   logic [2*WIDTH-1:0]           req_dbl;
   logic [2*WIDTH-1:0]           un_dbl;
   logic [WIDTH-1:0]             rot;
   logic [WIDTH-1:0]             rem;
   logic [WIDTH-1:0]             pick;
   logic [REQS-1:0][WIDTH-1:0]   sel_u;
   logic [WIDTH-1:0]             nxt_gnt;
   logic [CW-1:0]                nxt_cnt;
   logic [PW-1:0]                nxt_ptr;
   int                           last_j;

   // Rotate so that bit 0 of rot is the requester sitting at ptr.
   assign req_dbl = {req, req};
   assign rot     = req_dbl[ptr +: WIDTH];

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latches).
      rem     = rot;
      pick    = '0;
      un_dbl  = '0;
      sel_u   = '0;
      nxt_gnt = '0;
      nxt_cnt = '0;
      last_j  = -1;
      for (int k = 0; k < REQS; k++) begin
         pick = rem & (~rem + WIDTH'(1));
         rem  = rem & ~pick;
         un_dbl   = {pick, pick} << ptr;
         sel_u[k] = un_dbl[2*WIDTH-1:WIDTH];
         nxt_gnt  = nxt_gnt | sel_u[k];
         if (pick != '0) nxt_cnt = nxt_cnt + CW'(1);
         for (int j = 0; j < WIDTH; j++)
            if (pick[j]) last_j = j;
      end
      nxt_ptr = ptr;
      if (last_j >= 0) nxt_ptr = PW'((int'(ptr) + last_j + 1) % WIDTH);
   end

   // gnt is registered alongside the slices so it never sees the search logic directly.
   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
      if (reset) begin
         gnt_bus   <= '0;
         gnt       <= '0;
         gnt_count <= '0;
         ptr       <= '0;
      end else if (!stall) begin
         if (en) begin
            gnt_bus   <= sel_u;
            gnt       <= nxt_gnt;
            gnt_count <= nxt_cnt;
            ptr       <= nxt_ptr;
         end else begin
            gnt_bus   <= '0;
            gnt       <= '0;
            gnt_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rr_psel_gen.sv
// Scoreboard bench for rr_psel_gen: directed vectors with hand-computed results,
// then a random phase checked against a wrap-around-scan reference model.
module tb_rr_psel_gen;

   localparam int REQS  = 3;
   localparam int WIDTH = 16;

   logic                  clock;
   logic                  reset;
   logic                  en;
   logic                  stall;
   logic [WIDTH-1:0]      req;
   logic [WIDTH*REQS-1:0] gnt_bus;
   logic [WIDTH-1:0]      gnt;
   logic [1:0]            gnt_count;
   logic [3:0]            ptr;

   rr_psel_gen #(.REQS(REQS), .WIDTH(WIDTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .stall     (stall),
      .req       (req),
      .gnt_bus   (gnt_bus),
      .gnt       (gnt),
      .gnt_count (gnt_count),
      .ptr       (ptr)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic        stall;
      logic [15:0] req;
      logic        rnd;
      logic [47:0] bus;
      logic [1:0]  cnt;
      logic [3:0]  ptr;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   wait_c[16];
   int   max_wait = 0;

   // reference model state for the random phase
   logic [47:0] m_bus;
   logic [1:0]  m_cnt;
   logic [3:0]  m_ptr;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic s, input logic [15:0] rq,
                       input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [1:0] c, input logic [3:0] p, input string nm);
      exp_t x;
      @(negedge clock);
      reset = r; en = e; stall = s; req = rq;
      x.rst = r; x.en = e; x.stall = s; x.req = rq; x.rnd = 1'b0;
      x.bus = {s2, s1, s0}; x.cnt = c; x.ptr = p; x.name = nm;
      sb.push_back(x);
   endtask

   task automatic rstep(input logic r, input logic e, input logic s, input logic [15:0] rq);
      exp_t x;
      int   k;
      int   last;
      @(negedge clock);
      reset = r; en = e; stall = s; req = rq;
      if (r) begin
         m_bus = '0; m_cnt = '0; m_ptr = '0;
      end else if (!s) begin
         m_bus = '0; m_cnt = '0;
         if (e) begin
            k = 0; last = -1;
            for (int j = 0; j < WIDTH; j++) begin
               int i;
               i = (int'(m_ptr) + j) % WIDTH;
               if (rq[i] && k < REQS) begin
                  m_bus[k*WIDTH + i] = 1'b1;
                  k++;
                  last = i;
               end
            end
            m_cnt = 2'(k);
            if (last >= 0) m_ptr = 4'((last + 1) % WIDTH);
         end
      end
      x.rst = r; x.en = e; x.stall = s; x.req = rq; x.rnd = 1'b1;
      x.bus = m_bus; x.cnt = m_cnt; x.ptr = m_ptr; x.name = "rnd";
      sb.push_back(x);
   endtask

   // Monitor: compares every cycle for which stimulus queued an expectation.
   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.name, "_bus"}, 64'(gnt_bus), 64'(e.bus));
         check({e.name, "_gnt"}, 64'(gnt), 64'(e.bus[15:0] | e.bus[31:16] | e.bus[47:32]));
         check({e.name, "_cnt"}, 64'(gnt_count), 64'(e.cnt));
         check({e.name, "_ptr"}, 64'(ptr), 64'(e.ptr));
         if (e.rnd) begin
            for (int r = 0; r < WIDTH; r++) begin
               if (e.rst || !e.req[r]) wait_c[r] = 0;
               else if (e.en && !e.stall) begin
                  if (gnt[r]) wait_c[r] = 0;
                  else begin
                     wait_c[r]++;
                     if (wait_c[r] > max_wait) max_wait = wait_c[r];
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; en = 1'b0; stall = 1'b0; req = '0;
      foreach (wait_c[i]) wait_c[i] = 0;

      step(1, 1, 0, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 0, 0,  "rst0");
      step(1, 1, 0, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 0, 0,  "rst1");
      step(0, 1, 0, 16'hffff, 16'h0001, 16'h0002, 16'h0004, 3, 3,  "full0");
      step(0, 1, 0, 16'hffff, 16'h0008, 16'h0010, 16'h0020, 3, 6,  "full1");
      step(0, 1, 0, 16'hffff, 16'h0040, 16'h0080, 16'h0100, 3, 9,  "full2");
      step(0, 1, 0, 16'hffff, 16'h0200, 16'h0400, 16'h0800, 3, 12, "full3");
      step(0, 1, 0, 16'hffff, 16'h1000, 16'h2000, 16'h4000, 3, 15, "full4");
      step(0, 1, 0, 16'hffff, 16'h8000, 16'h0001, 16'h0002, 3, 2,  "full5");
      step(0, 1, 0, 16'h0004, 16'h0004, 16'h0000, 16'h0000, 1, 3,  "to_ptr3");
      step(0, 1, 0, 16'h8001, 16'h8000, 16'h0001, 16'h0000, 2, 1,  "sparse");
      step(0, 1, 0, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 1, 6,  "to_ptr6");
      step(0, 0, 0, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 0, 6,  "en_lo0");
      step(0, 0, 0, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 0, 6,  "en_lo1");
      step(0, 1, 0, 16'hffff, 16'h0040, 16'h0080, 16'h0100, 3, 9,  "en_hi");
      step(0, 1, 1, 16'h0001, 16'h0040, 16'h0080, 16'h0100, 3, 9,  "stall0");
      step(0, 1, 1, 16'h0002, 16'h0040, 16'h0080, 16'h0100, 3, 9,  "stall1");
      step(0, 1, 1, 16'h0003, 16'h0040, 16'h0080, 16'h0100, 3, 9,  "stall2");
      step(0, 1, 0, 16'h0004, 16'h0004, 16'h0000, 16'h0000, 1, 3,  "unstall");
      step(1, 1, 1, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 0, 0,  "rst_stall");
      step(0, 1, 0, 16'hffff, 16'h0001, 16'h0002, 16'h0004, 3, 3,  "rst_rel");
      step(0, 1, 0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1, 0,  "wrap");
      step(0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0,  "noreq");

      rstep(1, 1, 0, 16'hffff);
      for (int n = 0; n < 300; n++)
         rstep(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
               16'($urandom) | 16'h0101);

      repeat (3) @(negedge clock);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("starve_bound", 64'(max_wait <= (WIDTH + REQS - 1) / REQS - 1), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_psel_gen.md
# rr_psel_gen

Registered round-robin multi-grant selector. Each cycle it chooses up to REQS requesters out of WIDTH request lines. The search starts at a rotating priority pointer, so every requester is eventually served. Sits in the dispatch/issue path wherever a fixed-priority psel_gen starves high-index requesters: RS entry selection, free-list allocation, CDB arbitration.

## Interface

- REQS, 3: maximum grants per cycle. Legal range 1 ≤ REQS ≤ WIDTH.
- WIDTH, 16: number of request lines. Must be ≥ 2.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; overrides every other input.
- en  input  1  when 0, no grants are issued and the pointer holds.
- stall  input  1  when 1, the grant registers, count and pointer all hold; req is ignored.
- req  input  WIDTH  request vector; bit i means requester i wants a grant.
- gnt_bus  output  WIDTH*REQS  registered grants; slice k is gnt_bus[k*WIDTH +: WIDTH].
- gnt  output  WIDTH  bitwise OR of all gnt_bus slices (registered).
- gnt_count  output  $clog2(REQS+1)  number of non-zero slices (registered).
- ptr  output  $clog2(WIDTH)  current priority pointer; exposed for debug and verification.

## Operation

- Search order: ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1, with indices taken modulo WIDTH.
- The first REQS set bits of req found in search order are selected.
  - The k-th selected index i sets gnt_bus slice k to one-hot bit i.
- Slice invariants:
  - Each slice is one-hot or zero.
  - Non-zero slices are contiguous from slice 0.
  - No requester appears in two slices.
- Fewer than REQS requests: the remaining high slices are zero.
  - gnt_count equals min(popcount(req), REQS).
- Pointer update when ≥1 grant is issued: ptr ← (last selected index + 1) mod WIDTH.
  - With zero grants, ptr holds.
- Priority of controls, highest first: reset, stall, en.
  - reset: ptr = 0; gnt_bus, gnt and gnt_count = 0.
  - stall = 1 (no reset): all registers hold their values.
  - en = 0 (no reset, no stall): gnt_bus, gnt and gnt_count are cleared to 0; ptr holds.
  - en = 1 (no reset, no stall): grants and ptr load per the search rules above.
- gnt has no glitch path. It is computed from the registered slices, or registered in parallel with them.
- The search logic is combinational over req and ptr.
  - Implement it as a rotate → fixed-priority multi-select → un-rotate.
  - An equivalent wrap-around scan is also acceptable.
  - Whichever is used, the result must be bit-identical to the search order above.

## Timing

- Latency is 1 cycle. req sampled at edge N appears on gnt_bus/gnt/gnt_count after edge N, and the new ptr is visible at the same time.
- Reset values: all outputs are 0, and ptr = 0, one edge after reset is sampled high.
- reset mid-operation, including with stall = 1: outputs and ptr are zero after that edge.
- Deasserting reset: the first grants appear one cycle after the first edge with reset = 0, en = 1 and stall = 0.
- Pointer wrap-around: if the last selected index is WIDTH-1, ptr becomes 0.
- A request granted at edge N that stays asserted is granted again at N+1 only if it is still among the first REQS in the new search order.
- Full demand (req all ones): every cycle grants REQS consecutive indices, and ptr advances by REQS mod WIDTH.

## Test plan

- Reset:
  - Assert reset for 2 cycles with req = 16'hffff and en = 1 → gnt_bus = 0, gnt = 0, gnt_count = 0, ptr = 0.
- Full demand rotation (REQS = 3, WIDTH = 16):
  - req = 16'hffff from ptr 0 → slices 0001/0002/0004, count 3, ptr 3.
  - Next cycle → 0008/0010/0020, ptr 6.
  - Sixth cycle, from ptr 15 → slices 8000/0001/0002, ptr 2.
- Sparse wrap:
  - With ptr = 3, req = 16'h8001 → slice0 = 8000, slice1 = 0001, slice2 = 0000, gnt = 8001, count 2, ptr 1.
- en low:
  - Drop en for 2 cycles at ptr = 6 → gnt_bus = 0 and count = 0 after the first edge; ptr stays 6.
  - Re-raise en with req = 16'hffff → slices 0040/0080/0100.
- stall:
  - Assert stall for 3 cycles while req increments every cycle → gnt_bus, gnt_count and ptr are unchanged.
  - On release, grants reflect the req present at the first unstalled edge.
- Random req with en toggling:
  - A scoreboard model checks the slice invariants, gnt = OR of the slices, count = min(popcount, REQS) and the ptr update rule.
  - Starvation check: every continuously asserted requester is granted within ceil(WIDTH/REQS) enabled cycles.
